// File: rtl/wb_master_pkg.sv
// Shared types and default widths for the Wishbone command master.
package wb_master_pkg;

    localparam int WBM_AW   = 32;
    localparam int WBM_DW   = 32;
    localparam int WBM_SELW = WBM_DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_e;

    typedef struct packed {
        logic                we;
        logic [WBM_AW-1:0]   adr;
        logic [WBM_DW-1:0]   dat;
        logic [WBM_SELW-1:0] sel;
    } wbm_cmd_t;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command/response handshake plus Wishbone initiator bus, bundled for the master.
interface wb_cmd_master_if
    import wb_master_pkg::*;
#(
    parameter int AW   = WBM_AW,
    parameter int DW   = WBM_DW,
    parameter int SELW = DW / 8
) ();

    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic            cmd_we_i;
    logic [AW-1:0]   cmd_adr_i;
    logic [DW-1:0]   cmd_dat_i;
    logic [SELW-1:0] cmd_sel_i;

    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [DW-1:0]   rsp_dat_o;
    logic            rsp_err_o;

    logic            wbm_cyc_o;
    logic            wbm_stb_o;
    logic            wbm_we_o;
    logic [AW-1:0]   wbm_adr_o;
    logic [DW-1:0]   wbm_dat_o;
    logic [SELW-1:0] wbm_sel_o;
    logic [DW-1:0]   wbm_dat_i;
    logic            wbm_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  rsp_ready_i, wbm_dat_i, wbm_ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output rsp_ready_i, wbm_dat_i, wbm_ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Counts cycles a strobe has been held; flags the last permitted cycle.
module wb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign expired = en && (count_reg == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one bus cycle per accepted command, bounded by an ack timeout.
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int AW             = WBM_AW,
    parameter int DW             = WBM_DW,
    parameter int SELW           = DW / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    wb_cmd_master_if.master   bus,
    output logic [15:0]       txn_cnt_o,
    output logic [7:0]        err_cnt_o
);

    wbm_state_e        state_reg, state_next;
    wbm_cmd_t          cmd_reg;
    logic [WBM_DW-1:0] rsp_dat_reg;
    logic              rsp_err_reg;
    logic [15:0]       txn_cnt_reg;
    logic [7:0]        err_cnt_reg;

    logic cmd_take;
    logic ack_done;
    logic tmo_done;
    logic tmo_expired;

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .clr     (state_reg != BUS),
        .en      (state_reg == BUS),
        .expired (tmo_expired)
    );

    always_comb begin
        state_next = state_reg;
        cmd_take   = 1'b0;
        ack_done   = 1'b0;
        tmo_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    cmd_take   = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                // Ack has priority over a timeout landing on the same cycle.
                if (bus.wbm_ack_i) begin
                    ack_done   = 1'b1;
                    state_next = RESP;
                end else if (tmo_expired) begin
                    tmo_done   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg   <= IDLE;
            cmd_reg     <= '0;
            rsp_dat_reg <= '0;
            rsp_err_reg <= 1'b0;
            txn_cnt_reg <= '0;
            err_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (cmd_take) begin
                cmd_reg <= '{we:  bus.cmd_we_i,
                             adr: WBM_AW'(bus.cmd_adr_i),
                             dat: WBM_DW'(bus.cmd_dat_i),
                             sel: WBM_SELW'(bus.cmd_sel_i)};
            end
            if (ack_done) begin
                rsp_dat_reg <= cmd_reg.we ? '0 : WBM_DW'(bus.wbm_dat_i);
                rsp_err_reg <= 1'b0;
            end else if (tmo_done) begin
                rsp_dat_reg <= '0;
                rsp_err_reg <= 1'b1;
            end
            if (ack_done || tmo_done) begin
                txn_cnt_reg <= txn_cnt_reg + 16'd1;
            end
            if (tmo_done && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    // cyc/stb decode straight from the state register so reset drops them at once.
    assign bus.cmd_ready_o = (state_reg == IDLE);
    assign bus.wbm_cyc_o   = (state_reg == BUS);
    assign bus.wbm_stb_o   = (state_reg == BUS);
    assign bus.rsp_valid_o = (state_reg == RESP);
    assign bus.rsp_dat_o   = DW'(rsp_dat_reg);
    assign bus.rsp_err_o   = rsp_err_reg;
    assign bus.wbm_we_o    = cmd_reg.we;
    assign bus.wbm_adr_o   = AW'(cmd_reg.adr);
    assign bus.wbm_dat_o   = DW'(cmd_reg.dat);
    assign bus.wbm_sel_o   = SELW'(cmd_reg.sel);
    assign txn_cnt_o       = txn_cnt_reg;
    assign err_cnt_o       = err_cnt_reg;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a small Wishbone slave responder and response scoreboard.
module tb_wb_cmd_master;

    localparam int N_B2B = 300;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic [15:0] txn_cnt;
    logic [7:0]  err_cnt;

    wb_cmd_master_if #(.AW(32), .DW(32), .SELW(4)) bus ();

    wb_cmd_master #(
        .AW(32), .DW(32), .SELW(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .bus       (bus),
        .txn_cnt_o (txn_cnt),
        .err_cnt_o (err_cnt)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave responder: ack after ack_delay strobe cycles (-1 = never).
    int          ack_delay  = -1;
    logic [31:0] rd_data    = 32'h0;
    logic        stray_ack  = 1'b0;
    int          stb_age    = 0;
    int          stb_cycles = 0;
    logic        unstable   = 1'b0;
    logic        seen_we    = 1'b0;
    logic [31:0] seen_adr   = 32'h0;
    logic [31:0] seen_dat   = 32'h0;
    logic [3:0]  seen_sel   = 4'h0;

    always @(negedge wb_clk_i) begin
        if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
            if (stb_age == 0) begin
                seen_we  = bus.wbm_we_o;
                seen_adr = bus.wbm_adr_o;
                seen_dat = bus.wbm_dat_o;
                seen_sel = bus.wbm_sel_o;
            end else if ({bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o} !==
                         {seen_we, seen_adr, seen_dat, seen_sel}) begin
                unstable = 1'b1;
            end
            bus.wbm_ack_i = stray_ack || (ack_delay >= 0 && stb_age == ack_delay);
            bus.wbm_dat_i = rd_data;
            stb_age++;
            stb_cycles++;
        end else begin
            bus.wbm_ack_i = stray_ack;
            bus.wbm_dat_i = 32'hDEAD_BEEF;
            stb_age = 0;
        end
    end

    task automatic step();
        @(negedge wb_clk_i);
        #1;
    endtask

    logic [31:0] last_dat;
    logic        last_err;
    int          txn_no = 0;

    // One command from IDLE to consumed response; optional back-pressure of 'hold' cycles.
    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int delay, input logic [31:0] rdata,
                           input int hold);
        int k;
        ack_delay  = delay;
        rd_data    = rdata;
        stb_cycles = 0;
        unstable   = 1'b0;
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        bus.cmd_sel_i   = sel;
        bus.cmd_valid_i = 1'b1;
        step();
        chk("stb_start", 64'(bus.wbm_stb_o), 64'd1);
        bus.cmd_valid_i = 1'b0;
        k = 0;
        while (!bus.rsp_valid_o && k < 40) begin
            step();
            k++;
        end
        chk("rsp_seen", 64'(bus.rsp_valid_o), 64'd1);
        last_dat = bus.rsp_dat_o;
        last_err = bus.rsp_err_o;
        txn_no++;
        $display("txn %0d we=%0d adr=%08h rsp dat=%08h err=%0d stb_cycles=%0d",
                 txn_no, we, adr, last_dat, last_err, stb_cycles);
        if (hold > 0) begin
            bus.cmd_adr_i   = 32'h3000_0FF0;
            bus.cmd_valid_i = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            step();
            chk("bp_valid", 64'(bus.rsp_valid_o), 64'd1);
            chk("bp_dat",   64'(bus.rsp_dat_o),   64'(last_dat));
            chk("bp_err",   64'(bus.rsp_err_o),   64'(last_err));
            chk("bp_ready", 64'(bus.cmd_ready_o), 64'd0);
            chk("bp_stb",   64'(bus.wbm_stb_o),   64'd0);
        end
        bus.cmd_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        step();
        bus.rsp_ready_i = 1'b0;
        chk("idle_after", 64'(bus.cmd_ready_o), 64'd1);
    endtask

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    task automatic present(input int i);
        bus.cmd_we_i  = i[0];
        bus.cmd_adr_i = 32'h3000_0000 + 32'(i) * 32'd4;
        bus.cmd_dat_i = 32'hD000_0000 | 32'(i);
        bus.cmd_sel_i = 4'(i) | 4'h1;
    endtask

    initial begin
        int   idx;
        int   ndone;
        int   cyc;
        logic accepted;
        exp_t e;
        exp_t g;

        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = 32'h0;
        bus.cmd_dat_i   = 32'h0;
        bus.cmd_sel_i   = 4'h0;
        bus.rsp_ready_i = 1'b0;
        bus.wbm_ack_i   = 1'b0;
        bus.wbm_dat_i   = 32'h0;

        // Reset state
        step(); step(); step();
        chk("rst_ready", 64'(bus.cmd_ready_o), 64'd1);
        chk("rst_cyc",   64'(bus.wbm_cyc_o),   64'd0);
        chk("rst_stb",   64'(bus.wbm_stb_o),   64'd0);
        chk("rst_rspv",  64'(bus.rsp_valid_o), 64'd0);
        chk("rst_adr",   64'(bus.wbm_adr_o),   64'd0);
        chk("rst_txn",   64'(txn_cnt),         64'd0);
        chk("rst_err",   64'(err_cnt),         64'd0);
        wb_rst_ni = 1'b1;
        step();

        // Write, slave acks 2 cycles after stb
        run_cmd(1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, 2, 32'hFFFF_FFFF, 0);
        chk("wr_we",     64'(seen_we),    64'd1);
        chk("wr_adr",    64'(seen_adr),   64'h3000_0004);
        chk("wr_dat",    64'(seen_dat),   64'hA5A5_5A5A);
        chk("wr_sel",    64'(seen_sel),   64'hF);
        chk("wr_stable", 64'(unstable),   64'd0);
        chk("wr_stbs",   64'(stb_cycles), 64'd3);
        chk("wr_rerr",   64'(last_err),   64'd0);
        chk("wr_rdat",   64'(last_dat),   64'd0);
        chk("wr_txn",    64'(txn_cnt),    64'd1);

        // Read with same-cycle ack
        run_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF, 0, 32'h1234_5678, 0);
        chk("rd_we",   64'(seen_we),    64'd0);
        chk("rd_rdat", 64'(last_dat),   64'h1234_5678);
        chk("rd_rerr", 64'(last_err),   64'd0);
        chk("rd_stbs", 64'(stb_cycles), 64'd1);
        chk("rd_txn",  64'(txn_cnt),    64'd2);

        // Timeout with no ack
        run_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, -1, 32'h55AA_55AA, 0);
        chk("to_stbs", 64'(stb_cycles), 64'd8);
        chk("to_rerr", 64'(last_err),   64'd1);
        chk("to_rdat", 64'(last_dat),   64'd0);
        chk("to_errc", 64'(err_cnt),    64'd1);
        chk("to_txn",  64'(txn_cnt),    64'd3);

        // Ack on the last permitted cycle beats the timeout
        run_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF, 7, 32'h0BAD_F00D, 0);
        chk("ta_stbs", 64'(stb_cycles), 64'd8);
        chk("ta_rerr", 64'(last_err),   64'd0);
        chk("ta_rdat", 64'(last_dat),   64'h0BAD_F00D);
        chk("ta_errc", 64'(err_cnt),    64'd1);
        chk("ta_txn",  64'(txn_cnt),    64'd4);

        // Back-pressure: response held for 5 cycles with a new command waiting
        run_cmd(1'b0, 32'h3000_0018, 32'h0, 4'h3, 1, 32'hCAFE_F00D, 5);
        chk("bp_rdat", 64'(last_dat), 64'hCAFE_F00D);
        chk("bp_txn",  64'(txn_cnt),  64'd5);

        // Reset in the middle of a bus cycle
        ack_delay = -1;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = 32'h3000_0020;
        bus.cmd_valid_i = 1'b1;
        step();
        bus.cmd_valid_i = 1'b0;
        step();
        chk("mr_stb_pre", 64'(bus.wbm_stb_o), 64'd1);
        wb_rst_ni = 1'b0;
        #1;
        chk("mr_cyc",   64'(bus.wbm_cyc_o),   64'd0);
        chk("mr_stb",   64'(bus.wbm_stb_o),   64'd0);
        chk("mr_rspv",  64'(bus.rsp_valid_o), 64'd0);
        chk("mr_txn",   64'(txn_cnt),         64'd0);
        chk("mr_errc",  64'(err_cnt),         64'd0);
        step();
        wb_rst_ni = 1'b1;
        stray_ack = 1'b1;
        step(); step(); step();
        chk("mr_ready", 64'(bus.cmd_ready_o), 64'd1);
        chk("mr_cyc2",  64'(bus.wbm_cyc_o),   64'd0);
        chk("mr_rspv2", 64'(bus.rsp_valid_o), 64'd0);
        chk("mr_txn2",  64'(txn_cnt),         64'd0);
        stray_ack = 1'b0;
        step();

        // Back-to-back commands with cmd_valid held high
        idx = 0;
        ndone = 0;
        cyc = 0;
        accepted = 1'b0;
        present(0);
        bus.cmd_valid_i = 1'b1;
        bus.rsp_ready_i = 1'b1;
        while (ndone < N_B2B && cyc < 20000) begin
            if (bus.rsp_valid_o) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    g.adr = seen_adr;
                    g.dat = bus.rsp_dat_o;
                    g.err = bus.rsp_err_o;
                    $display("b2b %0d adr=%08h rsp dat=%08h err=%0d", ndone, g.adr, g.dat, g.err);
                    chk("b2b_adr", 64'(g.adr), 64'(e.adr));
                    chk("b2b_rsp", {31'd0, g.err, g.dat}, {31'd0, e.err, e.dat});
                end else begin
                    chk("b2b_extra_rsp", 64'd1, 64'(exp_q.size()));
                end
                ndone++;
            end
            if (bus.cmd_ready_o && bus.cmd_valid_i) begin
                e.adr = bus.cmd_adr_i;
                e.err = (idx % 7 == 6);
                rd_data = 32'h5EED_0000 + 32'(idx);
                e.dat = (e.err || bus.cmd_we_i) ? 32'h0 : rd_data;
                ack_delay = e.err ? -1 : int'($urandom_range(0, 3));
                exp_q.push_back(e);
                accepted = 1'b1;
            end
            step();
            cyc++;
            if (accepted) begin
                idx++;
                accepted = 1'b0;
                if (idx < N_B2B) present(idx);
                else bus.cmd_valid_i = 1'b0;
            end
        end
        bus.cmd_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        chk("b2b_done", 64'(ndone),   64'(N_B2B));
        chk("b2b_txn",  64'(txn_cnt), 64'd300);
        chk("b2b_errc", 64'(err_cnt), 64'd42);
        step();

        // Long stall run drives the error counter into saturation
        for (int s = 0; s < 220; s++) begin
            run_cmd(1'b0, 32'h3000_1000, 32'h0, 4'hF, -1, 32'h0, 0);
        end
        chk("sat_errc", 64'(err_cnt), 64'd255);
        chk("sat_txn",  64'(txn_cnt), 64'd520);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
